// File: rtl/ir_cam_pkg.sv
// Shared encodings and constants for the IR camera sequencer: FSM states,
// init register/value ROM, poll pointer and report layout.
package ir_cam_pkg;

  typedef enum logic [3:0] {
    S_RST_WAIT,
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_INIT_GAP,
    S_POLL_IDLE,
    S_PTR_ISSUE,
    S_PTR_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_FAULT
  } state_e;

  localparam logic [2:0] INIT_ENTRIES = 3'd6;
  localparam logic [7:0] POLL_PTR     = 8'h36;
  localparam logic [4:0] REPORT_LEN   = 5'd16;
  localparam logic [4:0] OFS_XL       = 5'd1;
  localparam logic [4:0] OFS_YL       = 5'd2;
  localparam logic [4:0] OFS_S        = 5'd3;

  function automatic logic [7:0] init_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    init_reg = 8'h30;
      3'd1:    init_reg = 8'h30;
      3'd2:    init_reg = 8'h06;
      3'd3:    init_reg = 8'h08;
      3'd4:    init_reg = 8'h1A;
      default: init_reg = 8'h33;
    endcase
  endfunction

  function automatic logic [7:0] init_val(input logic [2:0] idx);
    case (idx)
      3'd0:    init_val = 8'h01;
      3'd1:    init_val = 8'h08;
      3'd2:    init_val = 8'h90;
      3'd3:    init_val = 8'hC0;
      3'd4:    init_val = 8'h40;
      default: init_val = 8'h33;
    endcase
  endfunction

endpackage

// File: rtl/ir_report_decode.sv
// Captures a 16-byte camera report, checks its length and decodes blob 1.
// Blob outputs and the update pulse appear the cycle after the read completes.
module ir_report_decode
  import ir_cam_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       cap_en_i,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_valid_i,
  input  logic       done_i,
  input  logic       nack_i,
  output logic       frame_ok_o,
  output logic [9:0] blob_x_o,
  output logic [9:0] blob_y_o,
  output logic       blob_valid_o,
  output logic       blob_update_o
);

  // Counting one past the report length lets an over-long frame fail the check.
  localparam logic [4:0] CNT_SAT = REPORT_LEN + 5'd1;

  logic [4:0] cnt_q, cnt_total;
  logic [7:0] xl_q, yl_q, s_q;
  logic [9:0] x_q, y_q, x_new, y_new;
  logic       v_q, upd_q, take, present;

  always_comb begin
    take      = cap_en_i && rx_valid_i;
    cnt_total = cnt_q;
    if (take && (cnt_q != CNT_SAT)) cnt_total = cnt_q + 5'd1;
    x_new      = {s_q[5:4], xl_q};
    y_new      = {s_q[7:6], yl_q};
    present    = !((x_new == 10'h3FF) && (y_new == 10'h3FF));
    frame_ok_o = done_i && !nack_i && (cnt_total == REPORT_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      xl_q  <= '0;
      yl_q  <= '0;
      s_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      v_q   <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      cnt_q <= clr_i ? 5'd0 : cnt_total;
      if (take) begin
        case (cnt_q)
          OFS_XL:  xl_q <= rx_byte_i;
          OFS_YL:  yl_q <= rx_byte_i;
          OFS_S:   s_q  <= rx_byte_i;
          default: ;
        endcase
      end
      if (frame_ok_o) begin
        if (present) begin
          x_q <= x_new;
          y_q <= y_new;
        end
        v_q   <= present;
        upd_q <= (present && ((x_new != x_q) || (y_new != y_q))) || (present != v_q);
      end
    end
  end

  assign blob_x_o      = x_q;
  assign blob_y_o      = y_q;
  assign blob_valid_o  = v_q;
  assign blob_update_o = upd_q;

endmodule

// File: rtl/ir_cam_ctrl.sv
// Sequences IR camera init writes and periodic report polls over the I2C
// byte engine; txn_start is registered so it follows a cycle with busy low.
module ir_cam_ctrl
  import ir_cam_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h58,
  parameter int unsigned INIT_GAP    = 100000,
  parameter int unsigned POLL_PERIOD = 1000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic       txn_start,
  output logic       txn_rw,
  output logic [6:0] txn_addr,
  output logic [4:0] txn_len,
  input  logic       txn_busy,
  input  logic       txn_done,
  input  logic       txn_nack,
  output logic [7:0] tx_byte,
  input  logic       tx_next,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [9:0] blob_x,
  output logic [9:0] blob_y,
  output logic       blob_valid,
  output logic       blob_update,
  output logic       init_done,
  output logic       fault
);

  state_e      state_q, state_d;
  logic [31:0] gap_q, gap_d, period_q, period_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  retry_q, retry_d, retry_inc;
  logic        start_q, start_d, rw_q, rw_d, done_q, done_d, fault_q, fault_d;
  logic [4:0]  len_q, len_d;
  logic [7:0]  txb_q, txb_d;
  logic        gap_hit, period_exp, retry_over, rd_clr, in_rd, frame_ok;

  assign in_rd = (state_q == S_RD_WAIT);

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    period_d   = period_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    start_d    = 1'b0;
    rw_d       = rw_q;
    len_d      = len_q;
    txb_d      = txb_q;
    done_d     = done_q;
    fault_d    = fault_q;
    rd_clr     = 1'b0;
    gap_hit    = (gap_q == INIT_GAP - 1);
    period_exp = (period_q >= POLL_PERIOD - 1);
    retry_inc  = retry_q + 4'd1;
    retry_over = ({28'd0, retry_inc} > MAX_RETRY);

    // Saturating at expiry is what keeps overrun expiries from queueing.
    if (done_q && !period_exp) period_d = period_q + 32'd1;

    case (state_q)
      S_RST_WAIT, S_INIT_GAP: begin
        if (gap_hit) begin
          gap_d = '0;
          if (idx_q == INIT_ENTRIES) begin
            done_d  = 1'b1;
            state_d = S_POLL_IDLE;
          end else begin
            state_d = S_INIT_ISSUE;
          end
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_INIT_ISSUE: if (!txn_busy) begin
        start_d = 1'b1;
        rw_d    = 1'b0;
        len_d   = 5'd2;
        txb_d   = init_reg(idx_q);
        state_d = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (tx_next) txb_d = init_val(idx_q);
        if (txn_done) begin
          if (txn_nack) begin
            retry_d = retry_inc;
            fault_d = retry_over;
            state_d = retry_over ? S_FAULT : S_INIT_GAP;
          end else begin
            retry_d = '0;
            idx_d   = idx_q + 3'd1;
            state_d = S_INIT_GAP;
          end
        end
      end
      S_POLL_IDLE: if (period_exp) state_d = S_PTR_ISSUE;
      S_PTR_ISSUE: if (!txn_busy) begin
        start_d  = 1'b1;
        rw_d     = 1'b0;
        len_d    = 5'd1;
        txb_d    = POLL_PTR;
        period_d = '0;
        state_d  = S_PTR_WAIT;
      end
      S_PTR_WAIT: if (txn_done) begin
        if (txn_nack) begin
          retry_d = retry_inc;
          fault_d = retry_over;
          state_d = retry_over ? S_FAULT : S_POLL_IDLE;
        end else begin
          retry_d = '0;
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: if (!txn_busy) begin
        start_d = 1'b1;
        rw_d    = 1'b1;
        len_d   = REPORT_LEN;
        rd_clr  = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: if (txn_done) begin
        if (frame_ok) begin
          retry_d = '0;
          state_d = S_POLL_IDLE;
        end else begin
          retry_d = retry_inc;
          fault_d = retry_over;
          state_d = retry_over ? S_FAULT : S_POLL_IDLE;
        end
      end
      S_FAULT: ;
      default: state_d = S_RST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RST_WAIT;
      gap_q    <= '0;
      period_q <= '0;
      idx_q    <= '0;
      retry_q  <= '0;
      start_q  <= 1'b0;
      rw_q     <= 1'b0;
      len_q    <= '0;
      txb_q    <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      start_q  <= start_d;
      rw_q     <= rw_d;
      len_q    <= len_d;
      txb_q    <= txb_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  ir_report_decode u_decode (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (rd_clr),
    .cap_en_i     (in_rd),
    .rx_byte_i    (rx_byte),
    .rx_valid_i   (rx_valid),
    .done_i       (in_rd && txn_done),
    .nack_i       (txn_nack),
    .frame_ok_o   (frame_ok),
    .blob_x_o     (blob_x),
    .blob_y_o     (blob_y),
    .blob_valid_o (blob_valid),
    .blob_update_o(blob_update)
  );

  assign txn_start = start_q;
  assign txn_rw    = rw_q;
  assign txn_addr  = DEV_ADDR;
  assign txn_len   = len_q;
  assign tx_byte   = txb_q;
  assign init_done = done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ir_cam_ctrl.sv
// Directed bench for ir_cam_ctrl: init table, retries/fault, report decode and reset abort.
module tb_ir_cam_ctrl;

  localparam int GAP = 20;
  localparam int PER = 120;

  logic       clk = 1'b0, rst = 1'b1;
  logic       txn_start, txn_rw, txn_busy = 1'b0, txn_done = 1'b0, txn_nack = 1'b0;
  logic [6:0] txn_addr;
  logic [4:0] txn_len;
  logic [7:0] tx_byte, rx_byte = 8'h00;
  logic       tx_next = 1'b0, rx_valid = 1'b0;
  logic [9:0] blob_x, blob_y;
  logic       blob_valid, blob_update, init_done, fault;

  ir_cam_ctrl #(.DEV_ADDR(7'h58), .INIT_GAP(GAP), .POLL_PERIOD(PER), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .txn_start(txn_start), .txn_rw(txn_rw), .txn_addr(txn_addr),
    .txn_len(txn_len), .txn_busy(txn_busy), .txn_done(txn_done), .txn_nack(txn_nack),
    .tx_byte(tx_byte), .tx_next(tx_next), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .blob_x(blob_x), .blob_y(blob_y), .blob_valid(blob_valid), .blob_update(blob_update),
    .init_done(init_done), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int prev_start = 0;
  logic [7:0] rx_frame [16];

  typedef struct { bit nack; logic [7:0] reg_b; logic [7:0] val_b; } init_rec_t;
  typedef struct {
    bit ptr_nack; bit rd_nack; int nrx; bit coinc;
    logic [7:0] b1, b2, b3; logic [9:0] ex, ey; bit ev, eu;
  } poll_rec_t;

  init_rec_t itab [13];
  poll_rec_t ptab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  task automatic wait_start(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (txn_start) seen = 1'b1;
    end
  endtask

  // Engine model for a write: two tx_next strobes (the second checks the hold), then done.
  task automatic do_write(input bit nack, output logic [7:0] b0, output logic [7:0] b1,
                          output logic [7:0] b2);
    txn_busy = 1'b1;
    b0 = tx_byte;
    tx_next = 1'b1;
    @(negedge clk);
    tx_next = 1'b0;
    chk("start_single", 32'(txn_start), 32'd0);
    b1 = tx_byte;
    tx_next = 1'b1;
    @(negedge clk);
    tx_next = 1'b0;
    b2 = tx_byte;
    txn_done = 1'b1;
    txn_nack = nack;
    @(negedge clk);
    txn_done = 1'b0;
    txn_nack = 1'b0;
    txn_busy = 1'b0;
  endtask

  task automatic do_read(input int nrx, input bit coinc, input bit nack);
    txn_busy = 1'b1;
    for (int i = 0; i < nrx; i++) begin
      rx_byte  = rx_frame[i];
      rx_valid = 1'b1;
      if (coinc && i == nrx - 1) begin
        txn_done = 1'b1;
        txn_nack = nack;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!coinc) begin
      txn_done = 1'b1;
      txn_nack = nack;
      @(negedge clk);
    end
    txn_done = 1'b0;
    txn_nack = 1'b0;
    txn_busy = 1'b0;
  endtask

  task automatic run_init(input int first, input int n);
    bit seen;
    logic [7:0] b0, b1, b2;
    for (int k = first; k < first + n; k++) begin
      wait_start(GAP + 40, seen);
      chk("init_start_seen", 32'(seen), 32'd1);
      if (!seen) break;
      chk_ge("init_spacing", cyc - prev_start, GAP);
      prev_start = cyc;
      chk("init_rw", 32'(txn_rw), 32'd0);
      chk("init_len", 32'(txn_len), 32'd2);
      do_write(itab[k].nack, b0, b1, b2);
      chk("init_reg", 32'(b0), 32'(itab[k].reg_b));
      chk("init_val", 32'(b1), 32'(itab[k].val_b));
      chk("init_hold", 32'(b2), 32'(itab[k].val_b));
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_start", 32'(txn_start), 32'd0);
    chk("rst_rw", 32'(txn_rw), 32'd0);
    chk("rst_addr", 32'(txn_addr), 32'h58);
    chk("rst_len", 32'(txn_len), 32'd0);
    chk("rst_txbyte", 32'(tx_byte), 32'd0);
    chk("rst_blob_x", 32'(blob_x), 32'd0);
    chk("rst_blob_y", 32'(blob_y), 32'd0);
    chk("rst_blob_valid", 32'(blob_valid), 32'd0);
    chk("rst_blob_update", 32'(blob_update), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    bit have_last;
    int last_ptr;
    logic [7:0] b0, b1, b2;

    // Init with entry 2 NACKed once (indices 0..6), then the fault run (7..12).
    itab[0]  = '{1'b0, 8'h30, 8'h01};
    itab[1]  = '{1'b0, 8'h30, 8'h08};
    itab[2]  = '{1'b1, 8'h06, 8'h90};
    itab[3]  = '{1'b0, 8'h06, 8'h90};
    itab[4]  = '{1'b0, 8'h08, 8'hC0};
    itab[5]  = '{1'b0, 8'h1A, 8'h40};
    itab[6]  = '{1'b0, 8'h33, 8'h33};
    itab[7]  = '{1'b0, 8'h30, 8'h01};
    itab[8]  = '{1'b0, 8'h30, 8'h08};
    itab[9]  = '{1'b1, 8'h06, 8'h90};
    itab[10] = '{1'b1, 8'h06, 8'h90};
    itab[11] = '{1'b1, 8'h06, 8'h90};
    itab[12] = '{1'b1, 8'h06, 8'h90};

    ptab[0] = '{1'b0, 1'b0, 16, 1'b1, 8'h34, 8'h12, 8'h90, 10'h134, 10'h212, 1'b1, 1'b1};
    ptab[1] = '{1'b0, 1'b0, 16, 1'b0, 8'h34, 8'h12, 8'h90, 10'h134, 10'h212, 1'b1, 1'b0};
    ptab[2] = '{1'b0, 1'b0, 16, 1'b0, 8'hFF, 8'hFF, 8'hFF, 10'h134, 10'h212, 1'b0, 1'b1};
    ptab[3] = '{1'b0, 1'b0, 15, 1'b0, 8'h55, 8'h66, 8'h00, 10'h134, 10'h212, 1'b0, 1'b0};
    ptab[4] = '{1'b0, 1'b0, 16, 1'b0, 8'h55, 8'h66, 8'h00, 10'h055, 10'h066, 1'b1, 1'b1};
    ptab[5] = '{1'b0, 1'b1, 16, 1'b0, 8'hAA, 8'hBB, 8'h00, 10'h055, 10'h066, 1'b1, 1'b0};
    ptab[6] = '{1'b1, 1'b0, 16, 1'b0, 8'h00, 8'h00, 8'h00, 10'h055, 10'h066, 1'b1, 1'b0};
    ptab[7] = '{1'b0, 1'b0, 16, 1'b0, 8'h10, 8'h20, 8'hF0, 10'h310, 10'h320, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    prev_start = cyc;

    run_init(0, 7);
    seen = 1'b0;
    for (int i = 0; i < GAP + 20 && !seen; i++) begin
      @(negedge clk);
      if (init_done) seen = 1'b1;
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_no_fault", 32'(fault), 32'd0);

    have_last = 1'b0;
    last_ptr  = 0;
    for (int p = 0; p < 8; p++) begin
      wait_start(PER + 40, seen);
      chk("ptr_start_seen", 32'(seen), 32'd1);
      if (!seen) break;
      if (have_last) chk_ge("poll_spacing", cyc - last_ptr, PER);
      have_last = 1'b1;
      last_ptr  = cyc;
      chk("ptr_rw", 32'(txn_rw), 32'd0);
      chk("ptr_len", 32'(txn_len), 32'd1);
      do_write(ptab[p].ptr_nack, b0, b1, b2);
      chk("ptr_byte", 32'(b0), 32'h36);
      chk("ptr_hold", 32'(b2), 32'h36);
      if (ptab[p].ptr_nack) begin
        chk("ptr_nack_no_update", 32'(blob_update), 32'd0);
        continue;
      end
      wait_start(20, seen);
      chk("rd_start_seen", 32'(seen), 32'd1);
      if (!seen) break;
      chk("rd_rw", 32'(txn_rw), 32'd1);
      chk("rd_len", 32'(txn_len), 32'd16);
      for (int i = 0; i < 16; i++) rx_frame[i] = 8'(8'hC0 + i);
      rx_frame[1] = ptab[p].b1;
      rx_frame[2] = ptab[p].b2;
      rx_frame[3] = ptab[p].b3;
      do_read(ptab[p].nrx, ptab[p].coinc, ptab[p].rd_nack);
      chk("blob_x", 32'(blob_x), 32'(ptab[p].ex));
      chk("blob_y", 32'(blob_y), 32'(ptab[p].ey));
      chk("blob_valid", 32'(blob_valid), 32'(ptab[p].ev));
      chk("blob_update", 32'(blob_update), 32'(ptab[p].eu));
      @(negedge clk);
      chk("blob_update_one_shot", 32'(blob_update), 32'd0);
    end
    chk("poll_no_fault", 32'(fault), 32'd0);

    // Reset in the middle of a read, then a stale done.
    wait_start(PER + 40, seen);
    chk("mid_ptr_seen", 32'(seen), 32'd1);
    do_write(1'b0, b0, b1, b2);
    wait_start(20, seen);
    chk("mid_rd_seen", 32'(seen), 32'd1);
    txn_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_byte  = 8'h11;
      rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    txn_busy = 1'b0;
    prev_start = cyc;
    repeat (3) @(negedge clk);
    txn_done = 1'b1;
    @(negedge clk);
    txn_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("stale_done_update", 32'(blob_update), 32'd0);
    chk("stale_done_init", 32'(init_done), 32'd0);
    chk("stale_done_start", 32'(txn_start), 32'd0);

    // Restart from RST_WAIT; entry 2 NACKed four times exhausts retries.
    run_init(7, 6);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_no_init_done", 32'(init_done), 32'd0);
    wait_start(3 * GAP + PER, seen);
    chk("fault_no_start", 32'(seen), 32'd0);
    chk("fault_sticky", 32'(fault), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
